counter_load_sched: RTL and testbench

- Round-robin scheduler that shares one 4-bit loadable up-counter (inputs load/load_val, output count) among NUM_REQ requesters.
- Arbitrates pending requests and drives the counter's load strobe and load value.
- Holds the counter for a fixed run window, then releases it to the next requester.
- Sits between the requester blocks and the counter; it is the only driver of the counter's load pins.

---
 rtl/counter_load_sched.sv | 142 ++++++++++++++
 tb/tb_counter_load_sched.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/counter_load_sched.sv
// Round-robin scheduler sharing one loadable up-counter among NUM_REQ requesters.
// Optional macro LOAD_VERIFY_EN adds a CHECK cycle that verifies the loaded value.
module counter_load_sched #(
  parameter int NUM_REQ    = 4,
  parameter int CW         = 4,
  parameter int RUN_CYCLES = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*CW-1:0] req_val,
  input  logic [CW-1:0]         cnt_count,
  output logic                  cnt_load,
  output logic [CW-1:0]         cnt_load_val,
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  ack,
  output logic                  done,
  output logic                  busy,
  output logic                  load_err
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int RW = $clog2(RUN_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [RW-1:0]   run_cnt;

  logic            pick_valid;
  logic [PW-1:0]   pick_idx;
  logic [CW-1:0]   pick_val;

  // Index offset from base, wrapped modulo NUM_REQ.
  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int offset);
    int sum;
    sum = (int'(base) + offset) % NUM_REQ;
    return PW'(sum);
  endfunction

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_valid && req[wrap_idx(ptr, k)]) begin
        pick_valid = 1'b1;
        pick_idx   = wrap_idx(ptr, k);
      end
    end
  end

  always_comb begin
    pick_val = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PW'(i) == pick_idx) pick_val = req_val[i*CW +: CW];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      run_cnt      <= '0;
      cnt_load     <= 1'b0;
      cnt_load_val <= '0;
      gnt          <= '0;
      ack          <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (pick_valid) begin
            state        <= LOAD;
            gnt          <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
            cnt_load     <= 1'b1;
            cnt_load_val <= pick_val;
            ack          <= 1'b1;
            busy         <= 1'b1;
            ptr          <= wrap_idx(pick_idx, 1);
          end
        end
        LOAD: begin
          cnt_load <= 1'b0;
          ack      <= 1'b0;
`ifdef LOAD_VERIFY_EN
          state    <= CHECK;
`else
          state    <= RUN;
          run_cnt  <= RW'(RUN_CYCLES - 1);
          done     <= (RUN_CYCLES == 1);
`endif
        end
        CHECK: begin
          state   <= RUN;
          run_cnt <= RW'(RUN_CYCLES - 1);
          done    <= (RUN_CYCLES == 1);
        end
        RUN: begin
          if (run_cnt == '0) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else begin
            run_cnt <= run_cnt - RW'(1);
            done    <= (run_cnt == RW'(1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LOAD_VERIFY_EN
  // Sticky: a single bad load is remembered until reset.
  always_ff @(posedge clk) begin
    if (rst)
      load_err <= 1'b0;
    else if (state == CHECK && cnt_count != cnt_load_val)
      load_err <= 1'b1;
  end
`else
  logic unused_count;
  assign unused_count = ^cnt_count;
  assign load_err     = 1'b0;
`endif

  a_gnt_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_load_ack   : assert property (@(posedge clk) disable iff (rst) cnt_load == ack);
  a_busy_gnt   : assert property (@(posedge clk) disable iff (rst) busy == (gnt != '0));

endmodule

// File: tb/tb_counter_load_sched.sv
// Directed self-checking bench for counter_load_sched with a 4-bit counter model.
// Compile with +define+LOAD_VERIFY_EN to also exercise the load-verify path.
module tb_counter_load_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_val;
  logic [3:0]  count;
  logic        cnt_load;
  logic [3:0]  cnt_load_val;
  logic [3:0]  gnt;
  logic        ack, done, busy, load_err;
  logic        ignore_load = 1'b0;

  int checks = 0;
  int errors = 0;
  int done_pulses;

  counter_load_sched #(.NUM_REQ(4), .CW(4), .RUN_CYCLES(5)) dut (
    .clk(clk), .rst(rst), .req(req), .req_val(req_val), .cnt_count(count),
    .cnt_load(cnt_load), .cnt_load_val(cnt_load_val), .gnt(gnt), .ack(ack),
    .done(done), .busy(busy), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // Shared counter; in broken mode it ignores loads and sits at 0.
  always_ff @(posedge clk) begin
    if (rst || ignore_load) count <= '0;
    else if (cnt_load)      count <= cnt_load_val;
    else                    count <= count + 4'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_load"}, {31'd0, cnt_load}, 0);
    check({tag, "_gnt"},  {28'd0, gnt}, 0);
    check({tag, "_ack"},  {31'd0, ack}, 0);
    check({tag, "_done"}, {31'd0, done}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_err"},  {31'd0, load_err}, 0);
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b1111;
    req_val = 16'h4321;

    // 1: reset held two cycles with all requests high
    step(); check_idle_outputs("rst1");
    step(); check_idle_outputs("rst2");
    check("rst_val", {28'd0, cnt_load_val}, 0);
    req = 4'b0000;
    rst = 1'b0;
    step(); check("idle_busy", {31'd0, busy}, 0);
    check("idle_gnt", {28'd0, gnt}, 0);

    // 2: single request, requester 1 loads 5
    req = 4'b0010;
    req_val = 16'h0050;
    step();
    check("t2_load", {31'd0, cnt_load}, 1);
    check("t2_val",  {28'd0, cnt_load_val}, 5);
    check("t2_gnt",  {28'd0, gnt}, 4'b0010);
    check("t2_ack",  {31'd0, ack}, 1);
    req = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("t2_count%0d", i), {28'd0, count}, 5 + i);
      check($sformatf("t2_done%0d", i), {31'd0, done}, (i == 4) ? 1 : 0);
      check($sformatf("t2_gnth%0d", i), {28'd0, gnt}, 4'b0010);
      check($sformatf("t2_ld%0d", i), {31'd0, cnt_load}, 0);
    end
    step();
    check("t2_busy_end", {31'd0, busy}, 0);
    check("t2_gnt_end",  {28'd0, gnt}, 0);
    check("t2_val_held", {28'd0, cnt_load_val}, 5);

    // 6: ptr=2; requester 0 wins, req[2] pulses during RUN and is ignored
    req = 4'b0001;
    req_val = 16'h0003;
    step();
    check("t6_gnt", {28'd0, gnt}, 4'b0001);
    req = 4'b0000;
    done_pulses = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (done) done_pulses++;
      if (i == 1) req = 4'b0100;
      if (i == 2) req = 4'b0000;
      if (i >= 5) begin
        check($sformatf("t6_nognt%0d", i), {28'd0, gnt}, 0);
        check($sformatf("t6_noload%0d", i), {31'd0, cnt_load}, 0);
      end
    end
    check("t6_done_once", done_pulses, 1);

    // 3: all requesting, round-robin from ptr=0 after reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1111;
    req_val = 16'h4321;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("t3_gnt%0d", k), {28'd0, gnt}, 32'd1 << k);
      check($sformatf("t3_val%0d", k), {28'd0, cnt_load_val}, k + 1);
      check($sformatf("t3_ack%0d", k), {31'd0, ack}, 1);
      step();
      check($sformatf("t3_cnt%0d", k), {28'd0, count}, k + 1);
      repeat (4) step();
      step();
      check($sformatf("t3_gap%0d", k), {31'd0, busy}, 0);
    end
    step();
    check("t3_gnt_wrap", {28'd0, gnt}, 4'b0001);

    // 4: reset in the third RUN cycle, then first grant is requester 0 again
    step(); step(); step();
    check("t4_busy_run", {31'd0, busy}, 1);
    rst = 1'b1;
    step();
    check_idle_outputs("t4_rst");
    rst = 1'b0;
    step();
    check("t4_gnt", {28'd0, gnt}, 4'b0001);
    check("t4_val", {28'd0, cnt_load_val}, 1);
    req = 4'b0000;
    repeat (8) step();

`ifdef LOAD_VERIFY_EN
    // 5: broken counter trips the sticky verify error
    rst = 1'b1;
    ignore_load = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b0001;
    req_val = 16'h000A;
    step(); req = 4'b0000;
    step();
    check("t5_err_check", {31'd0, load_err}, 0);
    step();
    check("t5_err_set", {31'd0, load_err}, 1);
    ignore_load = 1'b0;
    repeat (6) step();
    req = 4'b0010;
    req_val = 16'h0070;
    step(); req = 4'b0000;
    repeat (9) step();
    check("t5_err_sticky", {31'd0, load_err}, 1);
    rst = 1'b1;
    step();
    check("t5_err_rst", {31'd0, load_err}, 0);
    rst = 1'b0;
    req = 4'b0001;
    step(); req = 4'b0000;
    repeat (3) step();
    check("t5_err_clean", {31'd0, load_err}, 0);
    repeat (6) step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
